fetch_unit: RTL and testbench



---
 rtl/fetch_unit_if.sv | 28 ++
 rtl/fetch_unit.sv | 92 +++++++++
 tb/tb_fetch_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, redirect/hazard/control requests
// and the IF/ID pipeline buffer outputs toward decode.
interface fetch_unit_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] imem_addr;
  logic [DATA_WIDTH-1:0] imem_data;
  logic                  branch_taken;
  logic [DATA_WIDTH-1:0] branch_target;
  logic                  hazard_stall;
  logic                  flush;
  logic                  halt;
  logic [DATA_WIDTH-1:0] id_instruction;
  logic [DATA_WIDTH-1:0] id_pc_next;
  logic                  id_valid;
  logic                  halted;
  logic [15:0]           fetch_count;

  modport master (
    output imem_addr, id_instruction, id_pc_next, id_valid, halted, fetch_count,
    input  imem_data, branch_taken, branch_target, hazard_stall, flush, halt
  );

  modport slave (
    input  imem_addr, id_instruction, id_pc_next, id_valid, halted, fetch_count,
    output imem_data, branch_taken, branch_target, hazard_stall, flush, halt
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instruction memory and fills
// the IF/ID buffer, honouring halt, redirect, flush and hazard-stall requests.
module fetch_unit #(
  parameter int                    DATA_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 16'h0000,
  parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 16'h0000
) (
  input logic          clock,
  input logic          reset,
  fetch_unit_if.master bus
);

  typedef enum logic [0:0] {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t                state_r;
  logic [DATA_WIDTH-1:0] pc_r;
  logic [DATA_WIDTH-1:0] id_instruction_r;
  logic [DATA_WIDTH-1:0] id_pc_next_r;
  logic                  id_valid_r;
  logic                  halted_r;
  logic [15:0]           fetch_count_r;
  logic [DATA_WIDTH-1:0] pc_plus2_s;

  assign pc_plus2_s = pc_r + DATA_WIDTH'(2);

  // Single-action-per-edge fetch FSM; a stall simply leaves PC and IF/ID untouched.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r          <= ST_RUN;
      pc_r             <= RESET_PC;
      id_instruction_r <= NOP_INSTR;
      id_pc_next_r     <= {DATA_WIDTH{1'b0}};
      id_valid_r       <= 1'b0;
      halted_r         <= 1'b0;
      fetch_count_r    <= 16'h0000;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (bus.halt) begin
            state_r          <= ST_HALTED;
            halted_r         <= 1'b1;
            id_instruction_r <= NOP_INSTR;
            id_pc_next_r     <= {DATA_WIDTH{1'b0}};
            id_valid_r       <= 1'b0;
          end else if (bus.branch_taken) begin
            // Redirect wins over stall/flush so the wrong-path word is squashed.
            pc_r             <= bus.branch_target;
            id_instruction_r <= NOP_INSTR;
            id_pc_next_r     <= {DATA_WIDTH{1'b0}};
            id_valid_r       <= 1'b0;
          end else if (bus.flush) begin
            pc_r             <= pc_plus2_s;
            id_instruction_r <= NOP_INSTR;
            id_pc_next_r     <= {DATA_WIDTH{1'b0}};
            id_valid_r       <= 1'b0;
          end else if (bus.hazard_stall) begin
            pc_r             <= pc_r;
          end else begin
            pc_r             <= pc_plus2_s;
            id_instruction_r <= bus.imem_data;
            id_pc_next_r     <= pc_plus2_s;
            id_valid_r       <= 1'b1;
            if (fetch_count_r != 16'hFFFF) begin
              fetch_count_r <= fetch_count_r + 16'd1;
            end else begin
              fetch_count_r <= fetch_count_r;
            end
          end
        end
        ST_HALTED: begin
          state_r  <= ST_HALTED;
          halted_r <= 1'b1;
        end
        default: begin
          state_r  <= ST_RUN;
          halted_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.imem_addr      = pc_r;
  assign bus.id_instruction = id_instruction_r;
  assign bus.id_pc_next     = id_pc_next_r;
  assign bus.id_valid       = id_valid_r;
  assign bus.halted         = halted_r;
  assign bus.fetch_count    = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a reference model pushes the expected
// post-edge state each cycle, which is popped and compared after the edge.
module tb_fetch_unit;

  logic clock;
  logic reset;
  logic reset_w;
  int   n_cmp;
  int   n_err;

  fetch_unit_if #(.DATA_WIDTH(16)) bus ();
  fetch_unit_if #(.DATA_WIDTH(16)) bus_w ();

  fetch_unit #(.DATA_WIDTH(16), .RESET_PC(16'h0000), .NOP_INSTR(16'h0000)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.master)
  );

  fetch_unit #(.DATA_WIDTH(16), .RESET_PC(16'hFFFC), .NOP_INSTR(16'h0000)) dut_wrap (
    .clock (clock),
    .reset (reset_w),
    .bus   (bus_w.master)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [15:0] pc_next;
    logic        valid;
    logic        halted;
    logic [15:0] count;
  } exp_t;

  exp_t exp_q[$];

  logic [15:0] m_pc;
  logic [15:0] m_instr;
  logic [15:0] m_pcn;
  logic        m_valid;
  logic        m_halted;
  logic [15:0] m_cnt;

  function automatic logic [15:0] imem_fn(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0004: return 16'h3333;
      16'h0006: return 16'h4444;
      16'h0040: return 16'hABCD;
      default:  return a ^ 16'h5A5A;
    endcase
  endfunction

  assign bus.imem_data   = imem_fn(bus.imem_addr);
  assign bus_w.imem_data = imem_fn(bus_w.imem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, push, then pop and compare after the edge.
  task automatic cyc(input logic rst_i, input logic halt_i, input logic br_i,
                     input logic [15:0] tgt_i, input logic stall_i, input logic flush_i);
    exp_t e;
    exp_t g;
    @(negedge clock);
    reset             = rst_i;
    bus.halt          = halt_i;
    bus.branch_taken  = br_i;
    bus.branch_target = tgt_i;
    bus.hazard_stall  = stall_i;
    bus.flush         = flush_i;
    if (!rst_i) begin
      m_pc = 16'h0000; m_instr = 16'h0000; m_pcn = 16'h0000;
      m_valid = 1'b0; m_halted = 1'b0; m_cnt = 16'h0000;
    end else if (m_halted) begin
      m_pc = m_pc;
    end else if (halt_i) begin
      m_halted = 1'b1; m_instr = 16'h0000; m_valid = 1'b0;
    end else if (br_i) begin
      m_pc = tgt_i; m_instr = 16'h0000; m_valid = 1'b0;
    end else if (flush_i) begin
      m_pc = m_pc + 16'd2; m_instr = 16'h0000; m_valid = 1'b0;
    end else if (stall_i) begin
      m_pc = m_pc;
    end else begin
      m_instr = imem_fn(m_pc); m_pcn = m_pc + 16'd2; m_valid = 1'b1;
      m_pc = m_pc + 16'd2;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    e.addr = m_pc; e.instr = m_instr; e.pc_next = m_pcn;
    e.valid = m_valid; e.halted = m_halted; e.count = m_cnt;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    g = exp_q.pop_front();
    check_eq("imem_addr", bus.imem_addr, g.addr);
    check_eq("id_instruction", bus.id_instruction, g.instr);
    check_eq("id_valid", {15'd0, bus.id_valid}, {15'd0, g.valid});
    if (g.valid) check_eq("id_pc_next", bus.id_pc_next, g.pc_next);
    check_eq("halted", {15'd0, bus.halted}, {15'd0, g.halted});
    check_eq("fetch_count", bus.fetch_count, g.count);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] words [4];
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    reset_w = 1'b0;
    bus.halt = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 16'h0000;
    bus.hazard_stall = 1'b0; bus.flush = 1'b0;
    bus_w.halt = 1'b0; bus_w.branch_taken = 1'b0; bus_w.branch_target = 16'h0000;
    bus_w.hazard_stall = 1'b0; bus_w.flush = 1'b0;
    words[0] = 16'h1111; words[1] = 16'h2222; words[2] = 16'h3333; words[3] = 16'h4444;

    // Reset state and free run over imem[0..3]
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("rst_addr", bus.imem_addr, 16'h0000);
    check_eq("rst_instr", bus.id_instruction, 16'h0000);
    check_eq("rst_pcnext", bus.id_pc_next, 16'h0000);
    check_eq("rst_valid", {15'd0, bus.id_valid}, 16'h0000);
    check_eq("rst_count", bus.fetch_count, 16'h0000);
    for (int k = 1; k <= 4; k++) begin
      run(1);
      check_eq("free_instr", bus.id_instruction, words[k-1]);
      check_eq("free_pcnext", bus.id_pc_next, 16'(2 * k));
    end
    check_eq("free_count", bus.fetch_count, 16'd4);

    // One-cycle stall at PC=4, then redirect combined with stall
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    run(2);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    check_eq("stall_addr", bus.imem_addr, 16'h0004);
    check_eq("stall_instr", bus.id_instruction, 16'h2222);
    check_eq("stall_count", bus.fetch_count, 16'd2);
    run(1);
    check_eq("post_stall_instr", bus.id_instruction, 16'h3333);
    check_eq("post_stall_pcnext", bus.id_pc_next, 16'h0006);
    cyc(1'b1, 1'b0, 1'b1, 16'h0040, 1'b1, 1'b0);
    check_eq("br_addr", bus.imem_addr, 16'h0040);
    check_eq("br_valid", {15'd0, bus.id_valid}, 16'h0000);
    run(1);
    check_eq("br_target_instr", bus.id_instruction, 16'hABCD);

    // Halt at PC=6, inputs ignored while halted, reset recovers
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    run(3);
    cyc(1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("halt_halted", {15'd0, bus.halted}, 16'h0001);
    for (int i = 0; i < 10; i++)
      cyc(1'b1, i[0], i[0], 16'h0100, i[1], ~i[0]);
    check_eq("halt_addr", bus.imem_addr, 16'h0006);
    check_eq("halt_count", bus.fetch_count, 16'd3);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check_eq("unhalt_halted", {15'd0, bus.halted}, 16'h0000);
    check_eq("unhalt_addr", bus.imem_addr, 16'h0000);

    // Reset mid-stall with flush asserted
    run(2);
    cyc(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    check_eq("midrst_addr", bus.imem_addr, 16'h0000);
    check_eq("midrst_count", bus.fetch_count, 16'h0000);

    // Random mixes of all requests
    for (int i = 0; i < 300; i++) begin
      logic rst_i;
      rst_i = !(m_halted && ($urandom_range(0, 3) == 0));
      cyc(rst_i, $urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, 16'($urandom),
          $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0);
    end

    // PC wrap on the RESET_PC=FFFC instance
    @(negedge clock);
    reset_w = 1'b1;
    @(posedge clock); #1;
    check_eq("wrap_addr1", bus_w.imem_addr, 16'hFFFE);
    check_eq("wrap_instr1", bus_w.id_instruction, imem_fn(16'hFFFC));
    @(posedge clock); #1;
    check_eq("wrap_addr2", bus_w.imem_addr, 16'h0000);
    check_eq("wrap_pcnext", bus_w.id_pc_next, 16'h0000);
    check_eq("wrap_valid", {15'd0, bus_w.id_valid}, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
